// File: rtl/jmp_seq_ctrl.sv
// Jump-sequence controller: decodes jump/call/return/base-load ops for the jump-address unit
// and owns the hardware return-address stack. Optional macro JMP_SEQ_CTRL_HWM_EN adds max_depth.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a new op (op_ready=1)
// S_EXEC  | one-cycle execute; jump_take or base_reg_ld pulse is high
// S_FAULT | sticky overflow/underflow/illegal-op; waits for fault_clr
module jmp_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ret_addr,
    output logic             op_ready,
    output logic [1:0]       jmp_mode,
    output logic             base_reg_ld,
    output logic [WIDTH-1:0] lr_addr,
    output logic             jump_take,
    output logic [PTR_W:0]   sp,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             fault,
    input  logic             fault_clr
`ifdef JMP_SEQ_CTRL_HWM_EN
    ,
    output logic [PTR_W:0]   max_depth
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_JMP_ABS = 3'b001;
    localparam logic [2:0] OP_JMP_REL = 3'b010;
    localparam logic [2:0] OP_CALL    = 3'b011;
    localparam logic [2:0] OP_RET     = 3'b100;
    localparam logic [2:0] OP_LDBASE  = 3'b101;

    localparam logic [1:0] MODE_ABS = 2'b00;
    localparam logic [1:0] MODE_REL = 2'b01;
    localparam logic [1:0] MODE_RET = 2'b11;

    localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] SP_ZERO = '0;
    localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);

    state_t             state_q;
    logic [PTR_W:0]     sp_q;
    logic [1:0]         jmp_mode_q;
    logic [WIDTH-1:0]   lr_addr_q;
    logic               base_reg_ld_q;
    logic               jump_take_q;
    logic               fault_q;
    logic [WIDTH-1:0]   stack_q [DEPTH];

    logic               full_w;
    logic               empty_w;
    logic               accept_w;
    logic               push_w;
    logic [PTR_W:0]     sp_m1_w;
    logic [PTR_W-1:0]   wr_idx_w;
    logic [PTR_W-1:0]   rd_idx_w;

    assign full_w   = (sp_q == SP_FULL);
    assign empty_w  = (sp_q == SP_ZERO);
    assign accept_w = op_valid && (state_q == S_IDLE);
    assign push_w   = accept_w && (op == OP_CALL) && !full_w;
    assign sp_m1_w  = sp_q - SP_ONE;
    assign wr_idx_w = sp_q[PTR_W-1:0];
    assign rd_idx_w = sp_m1_w[PTR_W-1:0];

    // Stack storage is deliberately not reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_w) begin
            stack_q[wr_idx_w] <= ret_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sp_q          <= SP_ZERO;
            jmp_mode_q    <= MODE_ABS;
            lr_addr_q     <= '0;
            base_reg_ld_q <= 1'b0;
            jump_take_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            base_reg_ld_q <= 1'b0;
            jump_take_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_NOP: begin
                            end
                            OP_JMP_ABS: begin
                                jmp_mode_q  <= MODE_ABS;
                                jump_take_q <= 1'b1;
                                state_q     <= S_EXEC;
                            end
                            OP_JMP_REL: begin
                                jmp_mode_q  <= MODE_REL;
                                jump_take_q <= 1'b1;
                                state_q     <= S_EXEC;
                            end
                            OP_CALL: begin
                                if (!full_w) begin
                                    sp_q        <= sp_q + SP_ONE;
                                    jmp_mode_q  <= MODE_ABS;
                                    jump_take_q <= 1'b1;
                                    state_q     <= S_EXEC;
                                end else begin
                                    fault_q <= 1'b1;
                                    state_q <= S_FAULT;
                                end
                            end
                            OP_RET: begin
                                if (!empty_w) begin
                                    lr_addr_q   <= stack_q[rd_idx_w];
                                    sp_q        <= sp_m1_w;
                                    jmp_mode_q  <= MODE_RET;
                                    jump_take_q <= 1'b1;
                                    state_q     <= S_EXEC;
                                end else begin
                                    fault_q <= 1'b1;
                                    state_q <= S_FAULT;
                                end
                            end
                            OP_LDBASE: begin
                                base_reg_ld_q <= 1'b1;
                                state_q       <= S_EXEC;
                            end
                            default: begin
                                fault_q <= 1'b1;
                                state_q <= S_FAULT;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    // A concurrent op is dropped; only the clear is honoured.
                    if (fault_clr) begin
                        fault_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JMP_SEQ_CTRL_HWM_EN
    logic [PTR_W:0] max_depth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_depth_q <= SP_ZERO;
        end else if (sp_q > max_depth_q) begin
            max_depth_q <= sp_q;
        end
    end

    assign max_depth = max_depth_q;
`endif

    assign op_ready    = (state_q == S_IDLE);
    assign jmp_mode    = jmp_mode_q;
    assign base_reg_ld = base_reg_ld_q;
    assign lr_addr     = lr_addr_q;
    assign jump_take   = jump_take_q;
    assign sp          = sp_q;
    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign fault       = fault_q;

endmodule

// File: doc/jmp_seq_ctrl.md
Name: jmp_seq_ctrl

Overview:
- Sequences the jump-address unit: decodes jump/call/return/base-load operations and drives that unit's jmp_mode, base_reg_ld and lr_addr inputs.
- Owns a hardware return-address stack (LIFO) that pushes on CALL and pops on RET.
- Sits between instruction decode and the jump-address unit.
- Flags stack overflow/underflow as a sticky fault that blocks further operations until cleared.

Parameters:
- WIDTH, 8, address width; matches the jump unit's address width.
- DEPTH, 8, return-stack entries; must be a power of 2, at least 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  operation request.
- op  input  3  operation code: 000 NOP, 001 JMP_ABS, 010 JMP_REL, 011 CALL, 100 RET, 101 LDBASE, 11x reserved.
- ret_addr  input  WIDTH  return address pushed on CALL (PC+1 from the fetch stage).
- op_ready  output  1  controller can accept an op.
- jmp_mode  output  2  to the jump unit: 00 absolute/CALL, 01 base-relative, 11 RET.
- base_reg_ld  output  1  one-cycle pulse that loads the jump unit's base register.
- lr_addr  output  WIDTH  popped return address fed to the jump unit.
- jump_take  output  1  one-cycle pulse; the PC must load the jump unit's out_addr this cycle.
- sp  output  PTR_W+1  current stack occupancy, 0..DEPTH.
- stack_full  output  1  sp == DEPTH.
- stack_empty  output  1  sp == 0.
- fault  output  1  sticky overflow/underflow/illegal-op flag.
- fault_clr  input  1  clears fault; synchronous.

Behaviour:
- Reset (async, rst_n low): state=IDLE, sp=0, jmp_mode=00, lr_addr=0, base_reg_ld=0, jump_take=0, fault=0. Stack contents are not reset.
- Reset mid-operation aborts any pending EXEC; no pulse escapes after rst_n deasserts.
- FSM states: IDLE, EXEC, FAULT.
- op_ready = (state==IDLE). An op is accepted on a rising edge with op_valid && op_ready.
- IDLE, NOP accepted: no effect; stays IDLE.
- IDLE, JMP_ABS accepted: jmp_mode<=00; go EXEC.
- IDLE, JMP_REL accepted: jmp_mode<=01; go EXEC.
- IDLE, CALL accepted:
  - if !stack_full: stack[sp]<=ret_addr, sp<=sp+1, jmp_mode<=00; go EXEC.
  - if stack_full: fault<=1, sp unchanged; go FAULT.
- IDLE, RET accepted:
  - if !stack_empty: lr_addr<=stack[sp-1], sp<=sp-1, jmp_mode<=11; go EXEC.
  - if stack_empty: fault<=1; go FAULT.
- IDLE, LDBASE accepted: go EXEC with a base-load flag set.
- IDLE, reserved op accepted: fault<=1; go FAULT.
- EXEC, one cycle only:
  - jump ops: jump_take=1.
  - LDBASE: base_reg_ld=1, jump_take=0.
  - Then unconditionally return to IDLE.
- Latency: accept edge to jump_take/base_reg_ld = 1 cycle. Throughput is one op per 2 cycles.
- base_reg_ld and jump_take are registered, glitch-free, high exactly one cycle and low otherwise. base_reg_ld rises only in EXEC, so the jump unit's posedge latch sees one clean edge.
- jmp_mode and lr_addr hold their values after EXEC until the next accepted op.
- FAULT: op_ready=0, no pulses, sp and stack frozen. fault_clr=1 clears fault and returns to IDLE on the next edge.
- fault_clr in IDLE/EXEC has no effect (fault is already 0).
- Simultaneous op_valid and fault_clr in FAULT: op ignored; only the clear takes effect.
- Boundaries:
  - CALL at sp=DEPTH-1 succeeds; sp becomes DEPTH and stack_full=1.
  - RET at sp=1 succeeds; stack_empty=1 afterwards.
  - sp never wraps.

Optional Feature:
- Macro: JMP_SEQ_CTRL_HWM_EN.
- Defined: adds output max_depth [PTR_W:0], a high-water mark of sp.
  - Reset to 0 by rst_n.
  - Updated on every edge where sp > max_depth.
  - Not affected by fault_clr.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset then LDBASE: base_reg_ld high exactly the cycle after accept, jump_take=0, op_ready low that cycle and high the next.
- CALL with ret_addr=0x10, then CALL with ret_addr=0x20, then RET, then RET: sp goes 1,2,1,0. RETs give lr_addr=0x20 then 0x10, jmp_mode=11, one jump_take pulse each.
- DEPTH=8, 8 CALLs, then a 9th CALL: sp=8, stack_full=1 after the 8th. The 9th sets fault, op_ready=0, no jump_take, sp stays 8. fault_clr returns to IDLE; the next RET pops the 8th address.
- RET from reset (empty): fault=1, no jump_take, lr_addr stays 0. Further op_valid ignored until fault_clr.
- JMP_REL then JMP_ABS: jmp_mode=01 then 00 during the respective jump_take cycles. Reserved op 110 sets fault.
- rst_n low during EXEC of a CALL: jump_take never pulses; sp=0, state IDLE. With JMP_SEQ_CTRL_HWM_EN, max_depth=0 after reset, and 3 CALLs then 2 RETs leave max_depth=3.
